fp32_to_int32_seq: RTL and testbench

Multi-cycle converter from IEEE-754 single precision to 32-bit two's-complement signed integer, rounding toward zero. It sits downstream of the combinational FP32 adder and returns its packed `{sign, exponent, mantissa}` results to the integer datapath. Alignment uses a one-bit-per-cycle barrel-free shifter, so area stays minimal. A start/done handshake frames each conversion.

---
 rtl/fp32_to_int32_seq.sv | 179 +++++++++++++++++
 tb/tb_fp32_to_int32_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_seq.sv
// Sequential FP32 -> INT32 converter, round toward zero.
// Alignment is done one bit per cycle to avoid a barrel shifter.
module fp32_to_int32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        invalid
);

    localparam int unsigned W    = 32;
    localparam int unsigned EW   = 8;
    localparam int unsigned MW   = 23;
    localparam int unsigned CW   = 5;
    localparam int unsigned PADW = W - MW - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            left_q, left_d;
    logic            special_q, special_d;
    logic [W-1:0]    preset_q, preset_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic            inv_pend_q, inv_pend_d;
    logic [W-1:0]    result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic            invalid_q, invalid_d;

    // Operand field decode
    logic                a_sign;
    logic [EW-1:0]       a_exp;
    logic [MW-1:0]       a_man;
    logic signed [EW:0]  a_e;
    logic [EW-1:0]       e_u;
    logic [W-1:0]        sat_val;

    assign a_sign  = A[W-1];
    assign a_exp   = A[W-2:MW];
    assign a_man   = A[MW-1:0];
    assign a_e     = $signed({1'b0, a_exp}) - 9'sd127;
    assign e_u     = a_exp - 8'd127;
    assign sat_val = a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            left_q     <= 1'b0;
            special_q  <= 1'b0;
            preset_q   <= '0;
            ovf_pend_q <= 1'b0;
            inv_pend_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            left_q     <= left_d;
            special_q  <= special_d;
            preset_q   <= preset_d;
            ovf_pend_q <= ovf_pend_d;
            inv_pend_q <= inv_pend_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        left_d     = left_q;
        special_d  = special_q;
        preset_d   = preset_q;
        ovf_pend_d = ovf_pend_q;
        inv_pend_d = inv_pend_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    sign_d     = a_sign;
                    mag_d      = {{PADW{1'b0}}, 1'b1, a_man};
                    cnt_d      = '0;
                    left_d     = 1'b0;
                    special_d  = 1'b1;
                    preset_d   = '0;
                    ovf_pend_d = 1'b0;
                    inv_pend_d = 1'b0;
                    // Classification in priority order: NaN, Inf, |x|<1, out of range
                    if (a_exp == 8'hFF && a_man != '0) begin
                        inv_pend_d = 1'b1;
                        preset_d   = 32'h8000_0000;
                    end else if (a_exp == 8'hFF) begin
                        ovf_pend_d = 1'b1;
                        preset_d   = sat_val;
                    end else if (a_exp < 8'd127) begin
                        preset_d   = '0;
                    end else if (a_e >= 9'sd31) begin
                        if (A == 32'hCF00_0000) begin
                            preset_d   = 32'h8000_0000;
                        end else begin
                            ovf_pend_d = 1'b1;
                            preset_d   = sat_val;
                        end
                    end else begin
                        special_d = 1'b0;
                        if (a_e < 9'sd23) begin
                            left_d = 1'b0;
                            cnt_d  = CW'(8'd23 - e_u);
                        end else begin
                            left_d = 1'b1;
                            cnt_d  = CW'(e_u - 8'd23);
                        end
                    end
                    state_d = (!special_d && cnt_d != '0) ? S_SHIFT : S_FINISH;
                end
            end

            S_SHIFT: begin
                mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
                cnt_d = CW'(cnt_q - 1'b1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                // Normal magnitudes stay below 2^31, so negation cannot wrap
                result_d   = special_q ? preset_q : (sign_q ? (~mag_q + 32'd1) : mag_q);
                overflow_d = ovf_pend_q;
                invalid_d  = inv_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Scoreboard bench for fp32_to_int32_seq: directed corner values plus random
// operands, checked against a real-arithmetic reference model.
module tb_fp32_to_int32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        invalid;

    fp32_to_int32_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .invalid  (invalid)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: build the exact value as a double and truncate it.
    function automatic exp_t model(input logic [31:0] a, input int c0);
        exp_t        r;
        logic        s;
        logic [7:0]  ex;
        logic [22:0] m;
        logic [63:0] d;
        real         v;
        int          e;
        int          n;
        s = a[31];
        ex = a[30:23];
        m = a[22:0];
        r.a = a;
        r.ovf = 1'b0;
        r.inv = 1'b0;
        r.res = 32'h0;
        n = 0;
        if (ex == 8'hFF) begin
            if (m != 23'h0) begin
                r.inv = 1'b1;
                r.res = 32'h8000_0000;
            end else begin
                r.ovf = 1'b1;
                r.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (ex != 8'h00) begin
            d = {s, 11'(int'(ex) - 127 + 1023), m, 29'h0};
            v = $bitstoreal(d);
            if (v >= 2147483648.0) begin
                r.ovf = 1'b1;
                r.res = 32'h7FFF_FFFF;
            end else if (v < -2147483648.0) begin
                r.ovf = 1'b1;
                r.res = 32'h8000_0000;
            end else if (v == -2147483648.0) begin
                r.res = 32'h8000_0000;
            end else begin
                r.res = $rtoi(v);
                if (ex >= 8'd127) begin
                    e = int'(ex) - 127;
                    n = (e < 23) ? (23 - e) : (e - 23);
                end
            end
        end
        r.done_cyc = c0 + n + 1;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h with no request pending", result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result[%h]", e.a), result, e.res);
                check($sformatf("overflow[%h]", e.a), 32'(overflow), 32'(e.ovf));
                check($sformatf("invalid[%h]", e.a), 32'(invalid), 32'(e.inv));
                check($sformatf("latency[%h]", e.a), 32'(cyc), 32'(e.done_cyc));
                check($sformatf("busy_in_done[%h]", e.a), 32'(busy), 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, guard);
        end
    endtask

    task automatic issue(input logic [31:0] a, input bit spurious);
        wait_idle();
        start = 1'b1;
        A = a;
        @(posedge clk);
        #1;
        sb.push_back(model(a, cyc));
        start = 1'b0;
        A = $urandom;
        if (spurious) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (busy) begin
                    start = 1'b1;
                    A = $urandom;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
    endtask

    logic [31:0] dir_vec [12];

    initial begin
        int guard;
        logic [31:0] ra;
        dir_vec[0]  = 32'h3F80_0000;
        dir_vec[1]  = 32'hC2F6_0000;
        dir_vec[2]  = 32'h4B00_0000;
        dir_vec[3]  = 32'h4F00_0000;
        dir_vec[4]  = 32'hCF00_0000;
        dir_vec[5]  = 32'hFF80_0000;
        dir_vec[6]  = 32'h7FC0_0000;
        dir_vec[7]  = 32'h3F7F_FFFF;
        dir_vec[8]  = 32'hBFC0_0000;
        dir_vec[9]  = 32'h8000_0000;
        dir_vec[10] = 32'h4EFF_FFFF;
        dir_vec[11] = 32'h7F80_0000;

        rst = 1'b1;
        start = 1'b0;
        A = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_flags", {29'h0, busy, done, overflow | invalid}, 32'h0);
        rst = 1'b0;

        foreach (dir_vec[i]) issue(dir_vec[i], (i % 3) == 0);

        // Reset five edges into a 1.0 conversion, with start asserted alongside rst
        wait_idle();
        start = 1'b1;
        A = 32'h3F80_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_flags", 32'(overflow | invalid), 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        issue(32'h4B00_0000, 1'b0);
        issue(32'h4040_0000, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
                2: ra = {1'($urandom), 8'($urandom_range(126, 158)), 23'($urandom)};
                default: ra = {1'($urandom), 8'hFF, 23'($urandom_range(0, 1))};
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(ra, $urandom_range(0, 4) == 0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
